// File: rtl/acc_requant_packer.sv
// acc_requant_packer
//   Requantizes 24-bit MAC accumulator results to INT8/INT4 and packs the lanes
//   into DAT_W-wide words in the MAC operand-vector lane layout, ready to be
//   written back as next-layer activations.
//
//   Optional feature macro: ACC_REQUANT_SAT_CNT_EN (adds a clip counter).
//
// Ports
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_valid / o_ready   accumulator-side handshake
//   i_mode              0 INT8, 1 INT4, 2 INT4_VSQ, 3 treated as INT4
//   i_acc               signed accumulator result
//   i_shift             rounding arithmetic right-shift amount
//   i_last              element closes the current word
//   o_valid / i_ready   packed-word handshake
//   o_data              packed lanes, unused lanes zero
//   o_count             lanes filled in o_data (1..64)
//   o_mode              mode of the word in o_data
//   i_sat_clr           (macro only) clear the clip counter
//   o_sat_cnt           (macro only) saturating count of clipped elements
module acc_requant_packer #(
  parameter int ACC_W = 24,
  parameter int DAT_W = 256,
  parameter int SH_W  = 5
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [1:0]              i_mode,
  input  logic signed [ACC_W-1:0] i_acc,
  input  logic [SH_W-1:0]         i_shift,
  input  logic                    i_last,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [DAT_W-1:0]        o_data,
  output logic [6:0]              o_count,
  output logic [1:0]              o_mode
`ifdef ACC_REQUANT_SAT_CNT_EN
  ,
  input  logic                    i_sat_clr,
  output logic [15:0]             o_sat_cnt
`endif
);

  localparam logic [6:0] CAP8 = 7'(DAT_W / 8);
  localparam logic [6:0] CAP4 = 7'(DAT_W / 4);

  function automatic logic signed [32:0] round_shift(input logic signed [32:0] v,
                                                     input logic [SH_W-1:0] sh);
    logic signed [32:0] bias;
    if (sh == '0) return v;
    bias = 33'sd1 <<< (int'(sh) - 1);
    return (v + bias) >>> sh;
  endfunction

  // Returns {clipped, value}; INT4 results live in value[3:0].
  function automatic logic [8:0] saturate(input logic signed [32:0] r, input logic is_int4);
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    hi = is_int4 ? 33'sd7 : 33'sd127;
    lo = is_int4 ? -33'sd8 : -33'sd128;
    if (r > hi)      return {1'b1, hi[7:0]};
    else if (r < lo) return {1'b1, lo[7:0]};
    else             return {1'b0, r[7:0]};
  endfunction

  logic                    rdy_en_q, rdy_en_d;
  logic                    vld_p1_q, vld_p1_d;
  logic signed [32:0]      r_p1_q, r_p1_d;
  logic [1:0]              mode_p1_q, mode_p1_d;
  logic                    last_p1_q, last_p1_d;
  logic [DAT_W-1:0]        pack_p2_q, pack_p2_d;
  logic [6:0]              cnt_p2_q, cnt_p2_d;
  logic [1:0]              mode_p2_q, mode_p2_d;
  logic                    out_vld_q, out_vld_d;
  logic [DAT_W-1:0]        out_data_q, out_data_d;
  logic [6:0]              out_cnt_q, out_cnt_d;
  logic [1:0]              out_mode_q, out_mode_d;

  logic                    accept, stall, consume, close, mode_chg, out_free, is4, full;
  logic signed [32:0]      v_in;
  logic [8:0]              sat;
  logic [6:0]              cnt_inc;
  logic [DAT_W-1:0]        packed_word;

  always_comb begin
    rdy_en_d    = 1'b1;
    vld_p1_d    = vld_p1_q;
    r_p1_d      = r_p1_q;
    mode_p1_d   = mode_p1_q;
    last_p1_d   = last_p1_q;
    pack_p2_d   = pack_p2_q;
    cnt_p2_d    = cnt_p2_q;
    mode_p2_d   = mode_p2_q;
    out_vld_d   = out_vld_q;
    out_data_d  = out_data_q;
    out_cnt_d   = out_cnt_q;
    out_mode_d  = out_mode_q;

    // ---- stage 2: saturate and pack ----
    out_free = !out_vld_q || i_ready;
    is4      = (mode_p1_q != 2'd0);
    sat      = saturate(r_p1_q, is4);
    cnt_inc  = cnt_p2_q + 7'd1;
    full     = is4 ? (cnt_inc == CAP4) : (cnt_inc == CAP8);
    close    = full || last_p1_q;
    // An element of a different mode first flushes the open word, then is
    // placed on the following cycle into lane 0 of a fresh word.
    mode_chg = vld_p1_q && (cnt_p2_q != 7'd0) && (mode_p1_q != mode_p2_q);
    consume  = vld_p1_q && !mode_chg && (!close || out_free);

    packed_word = pack_p2_q;
    if (is4) packed_word[int'(cnt_p2_q[5:0]) * 4 +: 4] = sat[3:0];
    else     packed_word[int'(cnt_p2_q[4:0]) * 8 +: 8] = sat[7:0];

    // ---- output register ----
    if (out_vld_q && i_ready) out_vld_d = 1'b0;

    if (mode_chg && out_free) begin
      out_vld_d  = 1'b1;
      out_data_d = pack_p2_q;
      out_cnt_d  = cnt_p2_q;
      out_mode_d = mode_p2_q;
      pack_p2_d  = '0;
      cnt_p2_d   = 7'd0;
    end else if (consume) begin
      mode_p2_d = mode_p1_q;
      if (close) begin
        out_vld_d  = 1'b1;
        out_data_d = packed_word;
        out_cnt_d  = cnt_inc;
        out_mode_d = mode_p1_q;
        pack_p2_d  = '0;
        cnt_p2_d   = 7'd0;
      end else begin
        pack_p2_d = packed_word;
        cnt_p2_d  = cnt_inc;
      end
    end

    // ---- stage 1: widen, VSQ restore, rounding shift ----
    stall   = vld_p1_q && !consume;
    o_ready = rdy_en_q && !stall;
    accept  = i_valid && o_ready;

    v_in = {{(33 - ACC_W){i_acc[ACC_W-1]}}, i_acc};
    if (i_mode == 2'd2) v_in = v_in <<< 8;

    if (!stall) vld_p1_d = accept;
    if (accept) begin
      r_p1_d    = round_shift(v_in, i_shift);
      mode_p1_d = (i_mode == 2'd3) ? 2'd1 : i_mode;
      last_p1_d = i_last;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdy_en_q   <= 1'b0;
      vld_p1_q   <= 1'b0;
      pack_p2_q  <= '0;
      cnt_p2_q   <= 7'd0;
      mode_p2_q  <= 2'd0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_cnt_q  <= 7'd0;
      out_mode_q <= 2'd0;
    end else begin
      rdy_en_q   <= rdy_en_d;
      vld_p1_q   <= vld_p1_d;
      pack_p2_q  <= pack_p2_d;
      cnt_p2_q   <= cnt_p2_d;
      mode_p2_q  <= mode_p2_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_cnt_q  <= out_cnt_d;
      out_mode_q <= out_mode_d;
    end
  end

  // Stage-1 payload is qualified by vld_p1_q and needs no reset.
  always_ff @(posedge i_clk) begin
    r_p1_q    <= r_p1_d;
    mode_p1_q <= mode_p1_d;
    last_p1_q <= last_p1_d;
  end

  assign o_valid = out_vld_q;
  assign o_data  = out_data_q;
  assign o_count = out_cnt_q;
  assign o_mode  = out_mode_q;

`ifdef ACC_REQUANT_SAT_CNT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;
  logic        clip_ev;

  always_comb begin
    clip_ev   = consume && sat[8];
    sat_cnt_d = sat_cnt_q;
    if (i_sat_clr)                             sat_cnt_d = clip_ev ? 16'd1 : 16'd0;
    else if (clip_ev && sat_cnt_q != 16'hFFFF) sat_cnt_d = sat_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sat_cnt_q <= 16'd0;
    else          sat_cnt_q <= sat_cnt_d;
  end

  assign o_sat_cnt = sat_cnt_q;
`endif

endmodule

// File: doc/acc_requant_packer.md
Name: acc_requant_packer

Overview:
- Sits at the output end of the MAC array and consumes its 24-bit accumulator results.
- For INT4_VSQ results, restores the deferred 8-bit scale shift that the MAC datapath leaves out.
- Requantizes each result with a rounding right-shift and a saturating clip to INT8 or INT4.
- Packs the lanes into DAT_W-wide words in the same lane layout as the MAC operand vectors, so they can be written back as next-layer activations.
- Valid/ready on both sides; one requant pipeline stage, one pack register and one output register.

Parameters:
ACC_W, 24, accumulator input width (matches `ACC_W)
DAT_W, 256, packed output word width (matches `DAT_W)
SH_W, 5, width of the requant shift amount

Ports:
i_clk  input  1  clock
i_rst_n  input  1  reset
i_valid  input  1  accumulator result valid
o_ready  output  1  block can accept a result this cycle
i_mode  input  2  `INT8=0, `INT4=1, `INT4_VSQ=2; 3 is treated as `INT4
i_acc  input  ACC_W  signed accumulator result
i_shift  input  SH_W  arithmetic right-shift amount, 0..31
i_last  input  1  this result closes the current word (partial flush)
o_valid  output  1  packed word valid
i_ready  input  1  downstream accepts word
o_data  output  DAT_W  packed lanes
o_count  output  7  number of valid lanes in o_data, 1..64
o_mode  output  2  mode of the word in o_data

Behaviour:
- Clocking and reset: one clock, i_clk; reset i_rst_n is asynchronous, active-low. All state is reset-only; no synchronous clear.
- Reset values: o_valid=0, o_data=0, o_count=0, o_mode=0, pack lane counter=0, pipeline stage empty. o_ready is 1 one cycle after reset release.
- Accept rule: an element is accepted on a cycle where i_valid && o_ready.
- Stage 1 (registered on accept), signed 33-bit arithmetic:
  - v = i_acc sign-extended; if mode is INT4_VSQ, v = i_acc <<< 8.
  - If i_shift > 0: r = (v + (1 << (i_shift-1))) >>> i_shift (round half up). If i_shift = 0: r = v.
  - Stage 1 also carries mode and i_last.
- Stage 2 (pack):
  - Saturate r: INT8 clips to [-128,127]; INT4/INT4_VSQ clip to [-8,7].
  - INT8: lane k goes to pack bits [8k+7:8k], k = 0..31. INT4: lane k goes to bits [4k+3:4k], k = 0..63.
  - The lane counter increments per element.
- Word close: the word closes when the counter reaches 32 (INT8) or 64 (INT4), or when the element carries i_last.
  - On close, the pack register moves to the output register. Unused lanes are 0. o_count = lanes filled. The counter is cleared.
- Mode change mid-word: a stage-1 element whose mode differs from the open word's mode (counter > 0) first closes the open word with its current count. The element is then placed in lane 0 of a new word. This costs one extra stall cycle.
- Output register:
  - Loads when empty or when draining in the same cycle (o_valid && i_ready).
  - o_data, o_count and o_mode are held stable while o_valid && !i_ready.
- Backpressure: if a word must close while the output register is full and not draining, stage 2 stalls. Stage 1 then holds, and o_ready=0.
  - o_ready = !(stage1 full && stage2 stalled).
  - o_ready does not depend combinationally on i_valid.
- Latency: the element that closes a word, accepted at cycle N, gives o_valid=1 at cycle N+2 when there is no backpressure.
- Throughput: one element per cycle sustained when i_ready=1.
- Reset mid-operation discards the partial word, the stage-1 contents and the output word. No output is generated for them.

Optional Feature:
- Macro: ACC_REQUANT_SAT_CNT_EN.
- When defined:
  - Adds ports i_sat_clr (input, 1) and o_sat_cnt (output, 16).
  - o_sat_cnt counts elements clipped at stage 2, sticks at 16'hFFFF, is reset to 0, and is cleared by i_sat_clr.
  - If i_sat_clr and a clip occur in the same cycle, the count goes to 1.
- When undefined: these ports and the counter are absent; all other behaviour is identical.

Test Plan:
1. INT8, shift=0, i_acc=0..31 back-to-back, i_ready=1 -> one word; lane k = k; o_count=32; o_valid 2 cycles after the 32nd accept.
2. INT8, shift=4, i_acc = 24, -24, 5000, -5000 with i_last on the 4th -> lanes 2, -1, 127, -128; o_count=4; lanes 4..31 = 0; with the macro, o_sat_cnt=2.
3. INT4_VSQ, i_acc=3, shift=10 -> lane 1. i_acc=-100, shift=8 -> -8 (saturated). 64 elements -> o_count=64, o_mode=2.
4. Backpressure: i_ready=0 for 80 cycles while INT8 elements stream -> first word held stable, second word fills, o_ready drops; after i_ready=1, both words are delivered in order with no loss.
5. Three INT8 elements, then one INT4 element -> INT8 word with o_count=3 emitted first; the INT4 element lands in lane 0 of the next word.
6. i_rst_n low mid-word with o_valid=1 -> o_valid=0, o_count=0 immediately; after release, a fresh 32-element INT8 word produces o_count=32 with no stale lanes.
